// File: rtl/fx_slave_regs_if.sv
// fx bus bundle between the control block and one register bank.
// The control block drives the strobes; the bank returns fx_q.
interface fx_slave_regs_if;
  logic [15:0] fx_waddr;
  logic        fx_wr;
  logic [7:0]  fx_data;
  logic        fx_rd;
  logic [15:0] fx_raddr;
  logic [7:0]  fx_q;

  modport master (
    output fx_waddr, fx_wr, fx_data,
    output fx_rd, fx_raddr,
    input  fx_q
  );

  modport slave (
    input  fx_waddr, fx_wr, fx_data,
    input  fx_rd, fx_raddr,
    output fx_q
  );
endinterface

// File: rtl/fx_slave_regs.sv
// fx bus register bank: ids, ctrl, command strobes, sticky status
// with irq mask, and a snapshot-consistent microsecond timestamp.
module fx_slave_regs #(
  parameter logic [7:0] MOD_ID  = 8'h01,
  parameter logic [7:0] VERSION = 8'h10
) (
  input  logic       clk_sys,
  input  logic       rst,
  fx_slave_regs_if.slave fx,
  input  logic [7:0] dev_id,
  input  logic       pluse_us,
  input  logic [7:0] evt_in,
  output logic [7:0] ctrl_out,
  output logic [7:0] cmd_pulse,
  output logic       irq
);

  logic [7:0]  woff;
  logic [7:0]  roff;
  logic        wsel;
  logic        rsel;
  logic        w_ctrl;
  logic        w_cmd;
  logic        w_stat;
  logic        w_mask;
  logic        w_t0;
  logic        w_scr;
  logic        r_t0;

  logic [7:0]  ctrl_q;
  logic [7:0]  mask_q;
  logic [7:0]  scr_q;
  logic [7:0]  stat_q;
  logic [7:0]  sync1;
  logic [7:0]  sync2;
  logic [7:0]  sync3;
  logic [7:0]  rise;
  logic [7:0]  w1c;
  logic [31:0] cnt;
  logic [23:0] shadow;
  logic [7:0]  rdata;

  assign woff = fx.fx_waddr[7:0];
  assign roff = fx.fx_raddr[7:0];
  assign wsel = fx.fx_wr
    && (fx.fx_waddr[15:8] == MOD_ID);
  assign rsel = fx.fx_rd
    && (fx.fx_raddr[15:8] == MOD_ID);

  assign w_ctrl = wsel && (woff == 8'h10);
  assign w_cmd  = wsel && (woff == 8'h11);
  assign w_stat = wsel && (woff == 8'h12);
  assign w_mask = wsel && (woff == 8'h13);
  assign w_t0   = wsel && (woff == 8'h20);
  assign w_scr  = wsel && (woff == 8'h30);
  assign r_t0   = rsel && (roff == 8'h20);

  // edge detect sits behind the 2-flop synchronizer
  assign rise = sync2 & ~sync3;
  assign w1c  = w_stat ? fx.fx_data : 8'h00;

  assign ctrl_out = ctrl_q;

  always_comb begin
    rdata = 8'h00;
    if (rsel) begin
      unique case (1'b1)
        roff == 8'h00: rdata = MOD_ID;
        roff == 8'h01: rdata = VERSION;
        roff == 8'h02: rdata = dev_id;
        roff == 8'h10: rdata = ctrl_q;
        roff == 8'h12: rdata = stat_q;
        roff == 8'h13: rdata = mask_q;
        roff == 8'h20: rdata = cnt[7:0];
        roff == 8'h21: rdata = shadow[7:0];
        roff == 8'h22: rdata = shadow[15:8];
        roff == 8'h23: rdata = shadow[23:16];
        roff == 8'h30: rdata = scr_q;
        default:       rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      mask_q    <= '0;
      scr_q     <= '0;
      stat_q    <= '0;
      sync1     <= '0;
      sync2     <= '0;
      sync3     <= '0;
      cnt       <= '0;
      shadow    <= '0;
      cmd_pulse <= '0;
      irq       <= 1'b0;
      fx.fx_q   <= '0;
    end else begin
      sync1 <= evt_in;
      sync2 <= sync1;
      sync3 <= sync2;
      // set wins over a same-cycle clear
      stat_q <= (stat_q & ~w1c) | rise;
      irq    <= |(stat_q & mask_q);
      cmd_pulse <= w_cmd ? fx.fx_data : 8'h00;
      if (w_ctrl) ctrl_q <= fx.fx_data;
      if (w_mask) mask_q <= fx.fx_data;
      if (w_scr)  scr_q  <= fx.fx_data;
      if (w_t0)
        cnt <= '0;
      else if (pluse_us)
        cnt <= cnt + 32'd1;
      if (r_t0) shadow <= cnt[31:8];
      if (fx.fx_rd) fx.fx_q <= rdata;
    end
  end

endmodule

// File: doc/fx_slave_regs.md
Name: fx_slave_regs

Overview:
- fx-bus responder: the register-bank end of the fx bus driven by the control block (fx_waddr/fx_wr/fx_data write side, fx_raddr/fx_rd/fx_q read side).
- Instanced once per slave-FPGA function module. Decodes its own module page and exposes:
  - identification registers
  - a control register
  - self-clearing command pulses
  - sticky event status with interrupt mask
  - a snapshot-consistent 32-bit microsecond timestamp.

Parameters:
MOD_ID  8'h01  module page; fx address bits [15:8] must equal this to select the block
VERSION  8'h10  value returned by the version register

Ports:
clk_sys  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
fx_waddr  in  16  write address
fx_wr  in  1  write strobe, one cycle per write
fx_data  in  8  write data, valid with fx_wr
fx_rd  in  1  read strobe, one cycle per read
fx_raddr  in  16  read address, valid with fx_rd
fx_q  out  8  read data, registered
dev_id  in  8  board device id, quasi-static
pluse_us  in  1  one-cycle pulse every microsecond
evt_in  in  8  asynchronous event inputs
ctrl_out  out  8  control register contents
cmd_pulse  out  8  one-cycle command strobes
irq  out  1  interrupt request, registered

Behaviour:
- Reset: all outputs, registers, counter, shadow, sync flops = 0, asynchronously on rst high; synchronous release.
- Select: access is valid only when addr[15:8] == MOD_ID.
  - Unselected or unmapped writes are ignored.
  - Unselected or unmapped reads return 8'h00.
- Read timing:
  - fx_q is updated on the clock edge where fx_rd=1, so data is valid the cycle after the strobe.
  - fx_q holds its value while fx_rd=0.
- Same-cycle fx_wr and fx_rd to the same register: read returns the pre-write value.
- Register map (offset = addr[7:0]):
  - 0x00 RO MOD_ID.
  - 0x01 RO VERSION.
  - 0x02 RO dev_id (sampled at read).
  - 0x10 RW CTRL: drives ctrl_out directly from the register.
  - 0x11 WO CMD: write asserts cmd_pulse = fx_data for exactly the next cycle, then 0. Back-to-back writes give back-to-back pulses. Reads return 0.
  - 0x12 STATUS R/W1C:
    - evt_in passes through a 2-flop synchronizer, then rising-edge detection.
    - A detected edge sets its bit; the bit is visible to a read 3 cycles after evt_in rises.
    - Writing 1 clears the bit; writing 0 has no effect.
    - Set and clear in the same cycle: set wins.
  - 0x13 RW MASK. irq = |(STATUS & MASK), registered: 1 cycle after the STATUS/MASK change.
  - 0x20–0x23 TIME (byte 0 at 0x20):
    - 32-bit counter, +1 on each pluse_us cycle, wraps FFFFFFFF→00000000.
    - Reading 0x20 returns cnt[7:0] live and, on the same edge, latches cnt[31:8] into a shadow.
    - 0x21/0x22/0x23 return shadow bytes 1/2/3, never live bits.
    - Any write to 0x20 clears the counter to 0 (wins over a same-cycle pluse_us). Writes to 0x21–0x23 are ignored.
  - 0x30 RW SCRATCH.
- No wait states; every strobe completes in one cycle; no backpressure.
- rst asserted mid-access: pending fx_q update and cmd_pulse are discarded; outputs go to 0 immediately.

Test Plan:
- Reset and ID: assert rst, check all outputs 0. With MOD_ID=01, dev_id=5A: read 0100/0101/0102 → fx_q=01/10/5A one cycle after each fx_rd. Read 0200 → 00.
- CTRL/SCRATCH/CMD: write 0110=A5 → ctrl_out=A5 next cycle, read back A5. Write 0111=81 twice back-to-back → cmd_pulse=81 for exactly 2 cycles, then 00. Read 0111 → 00.
- STATUS/irq: raise evt_in[3] → read 0112=08 at ≥3 cycles. MASK=00 → irq=0. Write 0113=08 → irq=1 one cycle later. Write 0112=08 in the same cycle as a new evt_in[3] edge → bit stays 1. Clean W1C → STATUS=00, irq=0.
- TIME snapshot: preload counter to 000000FE via clear plus 254 pluses. Read 0120 → FE. Apply 3 pluses, then read 0121/0122/0123 → 00/00/00 (shadow), not the live 01.
- Wrap and clear race: counter at FFFFFFFF, one pluse_us → 00000000. Write 0120 in the same cycle as pluse_us → counter 0.
- Same-cycle read/write: fx_wr 0130=33 with fx_rd 0130 while SCRATCH=11 → fx_q=11; next read → 33. rst asserted during a CMD write → cmd_pulse stays 0.
